// File: rtl/de2_115_sdram_pkg.sv
// Shared SDRAM sequencer definitions: command encodings,
// state encoding and the address bit used for PRECHARGE ALL.
package de2_115_sdram_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam int A10_BIT = 10;

    typedef enum logic [3:0] {
        S_WAIT_ENA,
        S_INIT_PRE,
        S_INIT_PRE_WAIT,
        S_INIT_REF,
        S_INIT_REF_WAIT,
        S_INIT_MRS,
        S_INIT_MRS_WAIT,
        S_READY,
        S_PRE,
        S_PRE_WAIT,
        S_REF,
        S_REF_WAIT
    } state_t;

endpackage

// File: rtl/de2_115_sdram_refresh_timer.sv
// Refresh interval counter and pending-credit tracker.
// DE2_SDRAM_REFRESH_POSTPONE_EN: 4-bit saturating credit count (max 8).
module de2_115_sdram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 624
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_dec,
    output logic o_ref_req,
    output logic o_overflow
);

    localparam int TW = $clog2(REFRESH_INTERVAL + 1);
`ifdef DE2_SDRAM_REFRESH_POSTPONE_EN
    localparam int PW   = 4;
    localparam int PMAX = 8;
`else
    localparam int PW   = 1;
    localparam int PMAX = 1;
`endif

    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          ref_req_q, ref_req_d;
    logic          overflow_q, overflow_d;
    logic          wrap;

    // Interval count, credit accounting and lost-credit detection
    always_comb begin
        wrap       = i_en && (timer_q == TW'(REFRESH_INTERVAL - 1));
        timer_d    = timer_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (!i_en || wrap) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
        if (wrap && !i_dec) begin
            if (pending_q == PW'(PMAX)) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PW'(1);
            end
        end else if (!wrap && i_dec && pending_q != '0) begin
            pending_d = pending_q - PW'(1);
        end
        ref_req_d = (pending_d != '0);
    end

    // Timer and credit registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer_q    <= '0;
            pending_q  <= '0;
            ref_req_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            ref_req_q  <= ref_req_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_ref_req  = ref_req_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/de2_115_sdram_sequencer.sv
// SDRAM power-up init and periodic refresh command sequencer.
// DE2_SDRAM_REFRESH_POSTPONE_EN: issue all owed refreshes per grant.
module de2_115_sdram_sequencer
    import de2_115_sdram_pkg::*;
#(
    parameter int          T_RP             = 2,
    parameter int          T_RFC            = 7,
    parameter int          T_MRD            = 2,
    parameter int          INIT_REFRESHES   = 8,
    parameter int          REFRESH_INTERVAL = 624,
    parameter logic [12:0] MODE_REG         = 13'h0020
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sdr_ena,
    input  logic        i_ref_gnt,
    output logic [3:0]  o_cmd,
    output logic [12:0] o_addr,
    output logic [1:0]  o_ba,
    output logic        o_bus_own,
    output logic        o_ref_req,
    output logic        o_ref_overflow,
    output logic        o_memory_initialized
);

    localparam int TMAX = (T_RP > T_RFC)
                        ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                        : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
    localparam int WW = $clog2(TMAX + 1);
    localparam int RW = $clog2(INIT_REFRESHES + 1);

    localparam logic [WW-1:0] RP_W  = WW'(T_RP > 1 ? T_RP - 2 : 0);
    localparam logic [WW-1:0] RFC_W = WW'(T_RFC > 1 ? T_RFC - 2 : 0);
    localparam logic [WW-1:0] MRD_W = WW'(T_MRD > 1 ? T_MRD - 2 : 0);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [RW-1:0] refs_q, refs_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [12:0]   addr_q, addr_d;
    logic          bus_own_q, bus_own_d;
    logic          init_q, init_d;
    logic          issue;
    logic          dec;
    logic          refs_done;
    logic          more_refs;

    assign refs_done = (refs_q == RW'(INIT_REFRESHES));

`ifdef DE2_SDRAM_REFRESH_POSTPONE_EN
    assign more_refs = o_ref_req;
`else
    assign more_refs = 1'b0;
`endif

    // Next state, then the one-cycle command for the state entered
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        refs_d    = refs_q;
        cmd_d     = CMD_NOP;
        addr_d    = '0;
        bus_own_d = bus_own_q;
        init_d    = init_q;
        issue     = 1'b0;
        dec       = 1'b0;
        unique case (state_q)
            S_WAIT_ENA: begin
                if (i_sdr_ena) begin
                    state_d = S_INIT_PRE;
                    issue   = 1'b1;
                end
            end
            S_INIT_PRE, S_INIT_PRE_WAIT,
            S_PRE, S_PRE_WAIT: begin
                if (state_q inside {S_INIT_PRE, S_PRE}
                    && T_RP > 1) begin
                    state_d = (state_q == S_PRE) ? S_PRE_WAIT
                                                 : S_INIT_PRE_WAIT;
                    wait_d  = RP_W;
                end else if (state_q inside {S_INIT_PRE, S_PRE}
                             || wait_q == '0) begin
                    state_d = (state_q inside {S_PRE, S_PRE_WAIT})
                            ? S_REF : S_INIT_REF;
                    issue   = 1'b1;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            S_INIT_REF, S_INIT_REF_WAIT: begin
                if (state_q == S_INIT_REF && T_RFC > 1) begin
                    state_d = S_INIT_REF_WAIT;
                    wait_d  = RFC_W;
                end else if (state_q == S_INIT_REF || wait_q == '0) begin
                    state_d = refs_done ? S_INIT_MRS : S_INIT_REF;
                    issue   = 1'b1;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            S_INIT_MRS, S_INIT_MRS_WAIT: begin
                if (state_q == S_INIT_MRS && T_MRD > 1) begin
                    state_d = S_INIT_MRS_WAIT;
                    wait_d  = MRD_W;
                end else if (state_q == S_INIT_MRS || wait_q == '0) begin
                    state_d   = S_READY;
                    bus_own_d = 1'b0;
                    init_d    = 1'b1;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            S_READY: begin
                if (o_ref_req && i_ref_gnt) begin
                    state_d   = S_PRE;
                    bus_own_d = 1'b1;
                    issue     = 1'b1;
                end
            end
            S_REF, S_REF_WAIT: begin
                if (state_q == S_REF && T_RFC > 1) begin
                    state_d = S_REF_WAIT;
                    wait_d  = RFC_W;
                end else if (state_q == S_REF || wait_q == '0) begin
                    if (more_refs) begin
                        state_d = S_REF;
                        issue   = 1'b1;
                    end else begin
                        state_d   = S_READY;
                        bus_own_d = 1'b0;
                    end
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: ;
        endcase
        if (issue) begin
            unique case (state_d)
                S_INIT_PRE, S_PRE: begin
                    cmd_d           = CMD_PRE;
                    addr_d[A10_BIT] = 1'b1;
                end
                S_INIT_REF: begin
                    cmd_d  = CMD_REF;
                    refs_d = refs_q + RW'(1);
                end
                S_REF: begin
                    cmd_d = CMD_REF;
                    dec   = 1'b1;
                end
                S_INIT_MRS: begin
                    cmd_d  = CMD_MRS;
                    addr_d = MODE_REG;
                end
                default: ;
            endcase
        end
    end

    // State and registered command-bus outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_WAIT_ENA;
            wait_q    <= '0;
            refs_q    <= '0;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            bus_own_q <= 1'b1;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            refs_q    <= refs_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            bus_own_q <= bus_own_d;
            init_q    <= init_d;
        end
    end

    de2_115_sdram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (init_q),
        .i_dec     (dec),
        .o_ref_req (o_ref_req),
        .o_overflow(o_ref_overflow)
    );

    assign o_cmd                = cmd_q;
    assign o_addr               = addr_q;
    assign o_ba                 = 2'b00;
    assign o_bus_own            = bus_own_q;
    assign o_memory_initialized = init_q;

endmodule

// File: tb/tb_de2_115_sdram_sequencer.sv
// Directed bench for the SDRAM init/refresh sequencer:
// init timeline, refresh service, overflow, reset abort, spurious grants.
module tb_de2_115_sdram_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        gnt = 1'b0;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        own;
    logic        req;
    logic        ovf;
    logic        init;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int ev_cyc[$];
    int ev_cmd[$];
    int ev_addr[$];
    int init_cyc;
    int own_fall;
    int req_fall;
    int own_first;

    int e, i_cyc, g, budget, tgt;

    de2_115_sdram_sequencer dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_sdr_ena           (ena),
        .i_ref_gnt           (gnt),
        .o_cmd               (cmd),
        .o_addr              (addr),
        .o_ba                (ba),
        .o_bus_own           (own),
        .o_ref_req           (req),
        .o_ref_overflow      (ovf),
        .o_memory_initialized(init)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_cmd.delete();
        ev_addr.delete();
        init_cyc  = -1;
        own_fall  = -1;
        req_fall  = -1;
        own_first = -1;
    endtask

    task automatic run_log(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (cmd != 4'b0111) begin
                ev_cyc.push_back(cyc);
                ev_cmd.push_back(int'(cmd));
                ev_addr.push_back(int'(addr));
            end
            if (own_first < 0) own_first = int'(own);
            if (init && init_cyc < 0) init_cyc = cyc;
            if (!own && own_fall < 0) own_fall = cyc;
            if (!req && req_fall < 0) req_fall = cyc;
        end
    endtask

    function automatic int evc(input int i);
        return (i < ev_cyc.size()) ? ev_cyc[i] : -1;
    endfunction

    function automatic int evk(input int i);
        return (i < ev_cmd.size()) ? ev_cmd[i] : -1;
    endfunction

    function automatic int eva(input int i);
        return (i < ev_addr.size()) ? ev_addr[i] : -1;
    endfunction

    task automatic verify_init(input int be);
        check("init_ncmd", ev_cyc.size(), 10);
        check("init_pre_cyc", evc(0) - be, 1);
        check("init_pre_cmd", evk(0), 4'b0010);
        check("init_pre_addr", eva(0), 13'h0400);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("init_ref%0d_cyc", k), evc(k) - be,
                  3 + 7 * (k - 1));
            check($sformatf("init_ref%0d_cmd", k), evk(k), 4'b0001);
        end
        check("init_mrs_cyc", evc(9) - be, 59);
        check("init_mrs_cmd", evk(9), 4'b0000);
        check("init_mrs_addr", eva(9), 13'h0020);
        check("init_done_cyc", init_cyc - be, 61);
        check("init_own_fall", own_fall - be, 61);
    endtask

    initial begin
        clear_log();
        // reset values
        tick();
        tick();
        check("rst_cmd", int'(cmd), 4'b0111);
        check("rst_addr", int'(addr), 0);
        check("rst_ba", int'(ba), 0);
        check("rst_own", int'(own), 1);
        check("rst_req", int'(req), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_init", int'(init), 0);

        // spurious grant while waiting for enable
        rst = 1'b0;
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_cmd", int'(cmd), 4'b0111);
            check("wait_own", int'(own), 1);
        end

        // full init with grant held high throughout
        ena = 1'b1;
        e = cyc;
        clear_log();
        run_log(70);
        gnt = 1'b0;
        verify_init(e);
        i_cyc = e + 61;

        // spurious grant with no refresh pending
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_gnt_cmd", int'(cmd), 4'b0111);
            check("idle_gnt_own", int'(own), 0);
        end
        gnt = 1'b0;

        // single refresh after first interval
        budget = 700;
        while (!req && budget > 0) begin
            tick();
            budget--;
        end
        check("req_rise_cyc", cyc - i_cyc, 624);
        g = cyc;
        gnt = 1'b1;
        clear_log();
        run_log(14);
        gnt = 1'b0;
        check("sr_ncmd", ev_cyc.size(), 2);
        check("sr_pre_cyc", evc(0) - g, 1);
        check("sr_pre_cmd", evk(0), 4'b0010);
        check("sr_pre_addr", eva(0), 13'h0400);
        check("sr_own_g1", own_first, 1);
        check("sr_ref_cyc", evc(1) - g, 3);
        check("sr_ref_cmd", evk(1), 4'b0001);
        check("sr_req_fall", req_fall - g, 3);
        check("sr_own_fall", own_fall - g, 10);

`ifdef DE2_SDRAM_REFRESH_POSTPONE_EN
        // three credits accumulated, drained within one grant
        tgt = i_cyc + 4 * 624;
        while (cyc < tgt) tick();
        check("pp_req", int'(req), 1);
        g = cyc;
        gnt = 1'b1;
        clear_log();
        run_log(30);
        gnt = 1'b0;
        check("pp_ncmd", ev_cyc.size(), 4);
        check("pp_pre_cyc", evc(0) - g, 1);
        check("pp_pre_cmd", evk(0), 4'b0010);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("pp_ref%0d_cyc", k), evc(k) - g,
                  3 + 7 * (k - 1));
            check($sformatf("pp_ref%0d_cmd", k), evk(k), 4'b0001);
        end
        check("pp_own_fall", own_fall - g, 24);
        check("pp_ovf", int'(ovf), 0);

        // nine intervals without grant: ninth credit is lost
        budget = 6000;
        while (!ovf && budget > 0) begin
            tick();
            budget--;
        end
        check("ovf_cyc", cyc - i_cyc, 13 * 624);
        check("ovf_req", int'(req), 1);
        tick();
        tick();
        check("ovf_sticky", int'(ovf), 1);
`else
        // two intervals without grant: second credit is lost
        budget = 2000;
        while (!ovf && budget > 0) begin
            tick();
            budget--;
        end
        check("ovf_cyc", cyc - i_cyc, 3 * 624);
        check("ovf_req", int'(req), 1);
        g = cyc;
        gnt = 1'b1;
        clear_log();
        run_log(14);
        gnt = 1'b0;
        check("ovf_srv_ncmd", ev_cyc.size(), 2);
        check("ovf_srv_ref_cyc", evc(1) - g, 3);
        check("ovf_sticky", int'(ovf), 1);
        check("ovf_srv_req", int'(req), 0);
        check("ovf_srv_own", int'(own), 0);
`endif

        // reset between REF3 and REF4 of a fresh init
        ena = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        ena = 1'b1;
        e = cyc;
        clear_log();
        run_log(20);
        check("mid_ncmd", ev_cyc.size(), 4);
        rst = 1'b1;
        #1;
        check("mid_cmd", int'(cmd), 4'b0111);
        check("mid_addr", int'(addr), 0);
        check("mid_own", int'(own), 1);
        check("mid_init", int'(init), 0);
        check("mid_ovf", int'(ovf), 0);
        check("mid_req", int'(req), 0);
        tick();
        rst = 1'b0;
        e = cyc;
        clear_log();
        run_log(70);
        verify_init(e);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/de2_115_sdram_sequencer.md
# de2_115_sdram_sequencer

Owns the SDRAM command bus during power-up and periodic refresh. After the clock/reset block raises its SDRAM-enable timeout, it issues the JEDEC init sequence (PRECHARGE ALL, N× AUTO REFRESH, LOAD MODE REGISTER) and then raises `o_memory_initialized`, which feeds system-ready generation. During normal operation it schedules refresh and obtains the bus from the main SDRAM controller through a req/gnt handshake. It runs in the 80 MHz memory clock domain.

## Interface

**Parameters**
- `T_RP`, default 2: precharge-to-command spacing, in cycles (≥1).
- `T_RFC`, default 7: refresh-to-command spacing, in cycles (≥1).
- `T_MRD`, default 2: mode-register-set to first command, in cycles (≥1).
- `INIT_REFRESHES`, default 8: number of AUTO REFRESH commands during init (≥1).
- `REFRESH_INTERVAL`, default 624: cycles between refresh credits (7.8 µs at 80 MHz).
- `MODE_REG`, default 13'h0020: value driven on `o_addr` with LOAD MODE REGISTER (CL2, burst length 1).

**Ports**
- `i_clk` — in, 1: memory clock; the only clock.
- `i_rst` — in, 1: asynchronous, active-high reset.
- `i_sdr_ena` — in, 1: SDRAM power-up timeout elapsed (level).
- `i_ref_gnt` — in, 1: controller idle with all banks closed; bus released.
- `o_cmd` — out, 4: {cs_n, ras_n, cas_n, we_n}.
- `o_addr` — out, 13: SDRAM address; A10=1 on PRECHARGE ALL.
- `o_ba` — out, 2: bank address; always 0.
- `o_bus_own` — out, 1: sequencer drives the command bus; external mux select.
- `o_ref_req` — out, 1: refresh pending.
- `o_ref_overflow` — out, 1: sticky flag; a refresh credit was lost.
- `o_memory_initialized` — out, 1: init complete (sticky until reset).

## Operation

- Command encodings: NOP=4'b0111, PRE=4'b0010, REF=4'b0001, MRS=4'b0000. Each command is driven for exactly one cycle; NOP is driven otherwise.
- All outputs are registered.
- **Init state machine:** WAIT_ENA → INIT_PRE → INIT_PRE_WAIT → INIT_REF → INIT_REF_WAIT (loops to INIT_REF until `INIT_REFRESHES` are issued) → INIT_MRS → INIT_MRS_WAIT → READY.
- `i_sdr_ena` is sampled only in WAIT_ENA; it is ignored once sampled high.
- **Service state machine:** READY → (`o_ref_req` && `i_ref_gnt`) → PRE → PRE_WAIT → REF → REF_WAIT.
- At the end of REF_WAIT:
  - if the pending count is still nonzero (postpone build only), go back to REF;
  - otherwise go to READY.
- `i_ref_gnt` is ignored outside READY, and ignored when `o_ref_req`=0.
- **Refresh timer:** starts at 0 in the cycle `o_memory_initialized` rises. It counts 0..`REFRESH_INTERVAL`-1 and wraps. Each wrap adds one credit to the pending count.
- `o_ref_req` = (pending != 0).
- Pending is decremented in the REF command cycle. A wrap in the same cycle as a decrement leaves pending unchanged.
- Reset values:
  - `o_cmd` = NOP; `o_addr` = 0; `o_ba` = 0;
  - `o_bus_own` = 1 (sequencer owns the bus until init completes);
  - `o_ref_req` = 0; `o_ref_overflow` = 0; `o_memory_initialized` = 0;
  - state = WAIT_ENA; timer = 0; pending = 0.
- Reset asserted mid-sequence aborts immediately to the reset values; init restarts on the next `i_sdr_ena`.

## Timing

- **Init timeline:** E = first cycle `i_sdr_ena` is sampled high.
  - PRE (A10=1) at E+1.
  - REF k at E+1+`T_RP`+(k-1)·`T_RFC`.
  - MRS at E+1+`T_RP`+`INIT_REFRESHES`·`T_RFC`.
  - `o_memory_initialized`=1 and `o_bus_own`=0 at MRS+`T_MRD`.
  - With the defaults: MRS at E+59, init complete at E+61.
- **Refresh service:** G = cycle in which `i_ref_gnt`=1 while in READY with `o_ref_req`=1.
  - `o_bus_own`=1 and PRE at G+1.
  - REF at G+1+`T_RP`.
  - `o_bus_own`=0 at G+1+`T_RP`+`T_RFC`, if no credit remains.
- The controller must keep its own commands off the bus while `o_bus_own`=1. It may issue from the cycle `o_bus_own` falls.

## Configuration

- `DE2_SDRAM_REFRESH_POSTPONE_EN` defined:
  - pending is a saturating 4-bit count, max 8;
  - all pending REFs are issued back-to-back within one grant (REF every `T_RFC` cycles, a single PRE);
  - a wrap while pending=8 sets `o_ref_overflow`.
- Undefined:
  - pending is 1 bit;
  - one REF is issued per grant;
  - a wrap while pending=1 sets `o_ref_overflow`.

## Structure

- Package `de2_115_sdram_pkg` holds:
  - the command encodings (NOP/PRE/REF/MRS);
  - the state enum;
  - the A10 bit-position constant.
- Sub-module `de2_115_sdram_refresh_timer`: interval counter plus pending counter/flag, and overflow detection. Outputs: `ref_req`, `overflow`. Input: decrement strobe.
- The top level holds both state machines and a shared wait counter sized to max(`T_RP`, `T_RFC`, `T_MRD`).

## Test plan

- **Reset then init:** reset, `i_sdr_ena` high at cycle E → PRE at E+1; REFs at E+3, E+10 … E+52; MRS with `o_addr`=13'h0020 at E+59; init=1 and `o_bus_own`=0 at E+61.
- **Single refresh:** grant at G, 624 cycles after init → PRE at G+1, REF at G+3, `o_bus_own` falls at G+10, `o_ref_req` falls at G+3.
- **Postponed refresh (macro on):** withhold grant for 3 intervals, then grant → 1 PRE, then 3 REFs spaced 7 cycles apart; `o_ref_overflow` stays 0.
- **Overflow:** withhold grant for 9 intervals (macro on), or for 2 intervals (macro off) → `o_ref_overflow`=1 and stays 1.
- **Reset mid-init:** assert `i_rst` between REF3 and REF4 → outputs return to reset values the same cycle; full init repeats on the next `i_sdr_ena`.
- **Spurious grant:** `i_ref_gnt`=1 with `o_ref_req`=0, and `i_ref_gnt`=1 during init → no command issued, `o_bus_own` unchanged.
